// File: rtl/flab5_pio_param.sv
// rtl/flab5_pio_param.sv - parametrised Avalon-MM parallel I/O port
//
// Purpose: bus-mapped PIO with per-bit direction, synchronised inputs,
// edge capture, maskable interrupt and atomic set/clear of the outputs.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   address     register word address (0 data, 1 direction, 2 irqmask,
//               3 edgecapture, 4 outset, 5 outclear, 6-7 reserved)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data, bits [WIDTH-1:0] used
//   readdata    zero-extended read data, combinational from address
//   in_port     asynchronous pin inputs
//   out_port    output data register
//   oe          per-bit output enable (1 = output)
//   irq         active-high interrupt request
module flab5_pio_param #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0,
  parameter int               EDGE_TYPE   = 0,
  parameter int               IRQ_TYPE    = 1,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] irq_src;
  logic [2:0]       arm_cnt;
  logic             armed;
  logic             wr;
  logic             unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign sync_in   = sync_q[SYNC_STAGES-1];
  // Edge detect stays off until the synchroniser and prev register hold
  // real post-reset samples, so levels present at release are not captured.
  assign armed     = (arm_cnt == ARM_MAX);

  // Input synchroniser chain and one-cycle history for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev <= sync_in;
    end
  end

  always_comb begin
    rise = sync_in & ~prev;
    fall = ~sync_in & prev;
    edge_hit = '0;
    if (armed) begin
      if (EDGE_TYPE == 0)      edge_hit = rise;
      else if (EDGE_TYPE == 1) edge_hit = fall;
      else                     edge_hit = rise | fall;
    end
  end

  assign clr = (wr && address == 3'd3) ? wd : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_port    <= RESET_VALUE;
      oe          <= RESET_DIR;
      irqmask     <= '0;
      edgecapture <= '0;
      arm_cnt     <= '0;
    end else begin
      if (!armed) arm_cnt <= arm_cnt + 3'd1;
      // A new edge wins over a write-1-to-clear in the same cycle.
      edgecapture <= (edgecapture & ~clr) | edge_hit;
      if (wr) begin
        case (address)
          3'd0: out_port <= wd;
          3'd1: oe       <= wd;
          3'd2: irqmask  <= wd;
          3'd4: out_port <= out_port | wd;
          3'd5: out_port <= out_port & ~wd;
          default: ;
        endcase
      end
    end
  end

  // Output bits read back the driven value, input bits the synchronised pin.
  always_comb begin
    readdata = '0;
    case (address)
      3'd0: readdata[WIDTH-1:0] = (out_port & oe) | (sync_in & ~oe);
      3'd1: readdata[WIDTH-1:0] = oe;
      3'd2: readdata[WIDTH-1:0] = irqmask;
      3'd3: readdata[WIDTH-1:0] = edgecapture;
      default: readdata = '0;
    endcase
  end

  assign irq_src = (IRQ_TYPE == 0) ? sync_in : edgecapture;
  assign irq     = |(irq_src & irqmask);

endmodule

// File: tb/tb_flab5_pio_param.sv
// tb/tb_flab5_pio_param.sv - self-checking bench for flab5_pio_param
module tb_flab5_pio_param;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  in_port = '0;
  logic [7:0]  out_port;
  logic [7:0]  oe;
  logic        irq;

  int n_checks = 0;
  int n_fail = 0;

  flab5_pio_param #(
    .WIDTH(8), .RESET_VALUE(8'h3C), .RESET_DIR(8'hF0),
    .EDGE_TYPE(0), .IRQ_TYPE(1), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: pin samples per clock since reset, register values.
  logic [7:0] m_out, m_oe, m_mask, m_ec;
  logic [7:0] m_samp[$];

  // Synchronised input after k clocks: the pin value sampled S-1 clocks earlier.
  function automatic logic [7:0] m_sync(int k);
    int j;
    j = k - S + 1;
    if (j < 1) return 8'h00;
    return m_samp[j-1];
  endfunction

  function automatic logic [31:0] m_read(logic [2:0] a);
    logic [7:0] s;
    s = m_sync(m_samp.size());
    case (a)
      3'd0: return {24'h0, (m_out & m_oe) | (s & ~m_oe)};
      3'd1: return {24'h0, m_oe};
      3'd2: return {24'h0, m_mask};
      3'd3: return {24'h0, m_ec};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    int k;
    logic [7:0] cur, old, ed, cl, d;
    if (reset) begin
      m_out = 8'h3C; m_oe = 8'hF0; m_mask = 8'h00; m_ec = 8'h00;
      m_samp.delete();
    end else begin
      k = m_samp.size() + 1;
      ed = 8'h00;
      if (k - 1 >= S + 1) begin
        cur = m_sync(k - 1);
        old = m_sync(k - 2);
        ed = cur & ~old;
      end
      m_samp.push_back(in_port);
      d = writedata[7:0];
      cl = 8'h00;
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_out = d;
          3'd1: m_oe = d;
          3'd2: m_mask = d;
          3'd3: cl = d;
          3'd4: m_out = m_out | d;
          3'd5: m_out = m_out & ~d;
          default: ;
        endcase
      end
      m_ec = (m_ec & ~cl) | ed;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    chipselect = 1'b0; write_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d,
                           input logic c, input logic w);
    @(negedge clk);
    address = a; writedata = d; chipselect = c; write_n = w;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic chk_rd(input string name, input logic [2:0] a, input logic [31:0] exp);
    @(negedge clk);
    address = a;
    #1;
    check(name, readdata, exp);
  endtask

  typedef struct {
    logic        cs;
    logic        wn;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [7:0]  exp_out;
    logic [7:0]  exp_oe;
    logic [2:0]  rd_addr;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [2:0] ra;

    vecs[0]  = '{1'b1, 1'b0, 3'd0, 32'h0000_00A5, 8'hA5, 8'hF0, 3'd0, 32'h0000_00A0};
    vecs[1]  = '{1'b1, 1'b0, 3'd4, 32'h0000_000A, 8'hAF, 8'hF0, 3'd4, 32'h0000_0000};
    vecs[2]  = '{1'b1, 1'b0, 3'd5, 32'h0000_0081, 8'h2E, 8'hF0, 3'd0, 32'h0000_0020};
    vecs[3]  = '{1'b1, 1'b0, 3'd1, 32'h0000_00FF, 8'h2E, 8'hFF, 3'd0, 32'h0000_002E};
    vecs[4]  = '{1'b0, 1'b0, 3'd0, 32'h0000_0055, 8'h2E, 8'hFF, 3'd1, 32'h0000_00FF};
    vecs[5]  = '{1'b1, 1'b1, 3'd0, 32'h0000_0055, 8'h2E, 8'hFF, 3'd0, 32'h0000_002E};
    vecs[6]  = '{1'b1, 1'b0, 3'd2, 32'hFFFF_FF5A, 8'h2E, 8'hFF, 3'd2, 32'h0000_005A};
    vecs[7]  = '{1'b1, 1'b0, 3'd6, 32'h0000_00FF, 8'h2E, 8'hFF, 3'd6, 32'h0000_0000};
    vecs[8]  = '{1'b1, 1'b0, 3'd7, 32'h0000_00FF, 8'h2E, 8'hFF, 3'd7, 32'h0000_0000};
    vecs[9]  = '{1'b1, 1'b0, 3'd2, 32'h0000_0000, 8'h2E, 8'hFF, 3'd2, 32'h0000_0000};
    vecs[10] = '{1'b1, 1'b0, 3'd3, 32'h0000_00FF, 8'h2E, 8'hFF, 3'd3, 32'h0000_0000};
    vecs[11] = '{1'b1, 1'b0, 3'd5, 32'hFFFF_FFFF, 8'h00, 8'hFF, 3'd0, 32'h0000_0000};

    // Reset values
    do_reset();
    check("rst_out_port", {24'h0, out_port}, 32'h3C);
    check("rst_oe", {24'h0, oe}, 32'hF0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    chk_rd("rst_rd0", 3'd0, 32'h30);
    chk_rd("rst_rd1", 3'd1, 32'hF0);
    chk_rd("rst_rd2", 3'd2, 32'h00);
    chk_rd("rst_rd3", 3'd3, 32'h00);
    chk_rd("rst_rd4", 3'd4, 32'h00);
    chk_rd("rst_rd5", 3'd5, 32'h00);

    // Register map vectors
    for (int i = 0; i < 12; i++) begin
      bus_write(vecs[i].addr, vecs[i].wd, vecs[i].cs, vecs[i].wn);
      check($sformatf("vec%0d_out", i), {24'h0, out_port}, {24'h0, vecs[i].exp_out});
      check($sformatf("vec%0d_oe", i), {24'h0, oe}, {24'h0, vecs[i].exp_oe});
      chk_rd($sformatf("vec%0d_rd", i), vecs[i].rd_addr, vecs[i].exp_rd);
    end

    // Input latency: data after 2 clocks, edgecapture after 3
    do_reset();
    bus_write(3'd1, 32'h0, 1'b1, 1'b0);
    in_port = 8'h0F;
    @(negedge clk);
    address = 3'd0; #1; check("lat1_data", readdata, 32'h00);
    address = 3'd3; #1; check("lat1_ec", readdata, 32'h00);
    @(negedge clk);
    address = 3'd0; #1; check("lat2_data", readdata, 32'h0F);
    address = 3'd3; #1; check("lat2_ec", readdata, 32'h00);
    @(negedge clk);
    address = 3'd3; #1; check("lat3_ec", readdata, 32'h0F);

    // IRQ, clear, and edge racing a clear
    bus_write(3'd3, 32'hFF, 1'b1, 1'b0);
    bus_write(3'd2, 32'h01, 1'b1, 1'b0);
    in_port = 8'h00;
    repeat (4) @(negedge clk);
    #1; check("irq_idle", {31'h0, irq}, 32'h0);
    in_port = 8'h01;
    repeat (3) @(negedge clk);
    #1; check("irq_edge", {31'h0, irq}, 32'h1);
    bus_write(3'd3, 32'h01, 1'b1, 1'b0);
    #1; check("irq_cleared", {31'h0, irq}, 32'h0);
    chk_rd("ec_cleared", 3'd3, 32'h00);
    in_port = 8'h00;
    repeat (4) @(negedge clk);
    in_port = 8'h01;
    repeat (2) @(negedge clk);
    address = 3'd3; writedata = 32'h01; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    #1; check("race_ec", readdata, 32'h01);
    check("race_irq", {31'h0, irq}, 32'h1);
    bus_write(3'd2, 32'h00, 1'b1, 1'b0);
    #1; check("mask_off_irq", {31'h0, irq}, 32'h0);
    chk_rd("mask_off_ec", 3'd3, 32'h01);

    // Levels held through reset release are not captured
    in_port = 8'hFF;
    do_reset();
    repeat (6) @(negedge clk);
    chk_rd("hold_ec", 3'd3, 32'h00);
    chk_rd("hold_data", 3'd0, 32'h3F);
    bus_write(3'd2, 32'hFF, 1'b1, 1'b0);
    #1; check("hold_irq", {31'h0, irq}, 32'h0);

    // Reset asserted during a direction write
    bus_write(3'd4, 32'h03, 1'b1, 1'b0);
    @(negedge clk);
    address = 3'd1; writedata = 32'hFF; chipselect = 1'b1; write_n = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("midwr_oe_async", {24'h0, oe}, 32'hF0);
    repeat (2) @(negedge clk);
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    @(negedge clk);
    check("midwr_oe", {24'h0, oe}, 32'hF0);
    check("midwr_out", {24'h0, out_port}, 32'h3C);
    chk_rd("midwr_mask", 3'd2, 32'h00);
    chk_rd("midwr_ec", 3'd3, 32'h00);

    // Randomised traffic against the reference model
    in_port = 8'h00;
    do_reset();
    for (int it = 0; it < 400; it++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
      address = 3'($urandom_range(0, 7));
      writedata = $urandom;
      chipselect = ($urandom_range(0, 4) != 0);
      write_n = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
      ra = 3'($urandom_range(0, 7));
      address = ra;
      #1;
      check($sformatf("rnd%0d_rd%0d", it, ra), readdata, m_read(ra));
      check($sformatf("rnd%0d_out", it), {24'h0, out_port}, {24'h0, m_out});
      check($sformatf("rnd%0d_oe", it), {24'h0, oe}, {24'h0, m_oe});
      check($sformatf("rnd%0d_irq", it), {31'h0, irq}, {31'h0, |(m_ec & m_mask)});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
